// File: rtl/johncount_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : johncount_ctrl_if
//  Description : Command/status bundle for the Johnson counter sequencer.
//                master  - system control logic (issues start/load/hold)
//                slave   - johncount_ctrl (owns the phase register)
//  Signals     : start, steps[CNT_W], dir, hold, load, load_q[WIDTH]  (m->s)
//                q[WIDTH], ready, busy, done, wrap, err                (s->m)
//  Revision    : 1.0  initial release
// ============================================================================
interface johncount_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] steps;
  logic             dir;
  logic             hold;
  logic             load;
  logic [WIDTH-1:0] load_q;
  logic [WIDTH-1:0] q;
  logic             ready;
  logic             busy;
  logic             done;
  logic             wrap;
  logic             err;

  modport master (
    output start, steps, dir, hold, load, load_q,
    input  q, ready, busy, done, wrap, err
  );

  modport slave (
    input  start, steps, dir, hold, load, load_q,
    output q, ready, busy, done, wrap, err
  );
endinterface
`default_nettype wire

// File: rtl/johncount_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : johncount_ctrl
//  Description : Command-driven sequencer owning a WIDTH-stage Johnson
//                (twisted-ring) counter. A run shifts the ring forward or
//                reverse for a requested number of steps under a
//                start/ready/done handshake, with pause (hold), preload
//                (load) and one-cycle wrap signalling on every return to 0.
//  Ports       : clk    - rising-edge clock
//                reset  - synchronous active-high reset
//                bus    - johncount_ctrl_if.slave command/status bundle
//  Options     : JC_SELF_CORRECT_EN - when defined, any non-Johnson code in
//                the register is forced to 0 at the next edge and a sticky
//                err flag is raised; a run in progress terminates early.
//                When undefined, err is tied low and no checking occurs.
//  Revision    : 1.0  initial release
// ============================================================================
module johncount_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  wire logic           clk,
  input  wire logic           reset,
  johncount_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_rem_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_rem_zero = '0;
  localparam logic [WIDTH-1:0] c_q_zero   = '0;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_rem;
  logic             r_dir;
  logic             r_wrap;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [CNT_W-1:0] w_rem_nxt;
  logic             w_dir_nxt;
  logic             w_wrap_nxt;

  // Both shift candidates; reverse is the exact inverse of forward.
  logic [WIDTH-1:0] w_q_fwd;
  logic [WIDTH-1:0] w_q_rev;
  logic [WIDTH-1:0] w_q_shift;

  assign w_q_fwd   = {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
  assign w_q_rev   = {~r_q[0], r_q[WIDTH-1:1]};
  assign w_q_shift = r_dir ? w_q_rev : w_q_fwd;

`ifdef JC_SELF_CORRECT_EN
  // A Johnson code has at most one boundary between adjacent bits. The
  // boundary vector has at most one bit set iff clearing its lowest set bit
  // leaves zero.
  logic [WIDTH-2:0] w_edges;
  logic             w_illegal;
  logic             r_err;

  assign w_edges   = r_q[WIDTH-1:1] ^ r_q[WIDTH-2:0];
  assign w_illegal = (w_edges & (w_edges - 1'b1)) != '0;
`endif

  // --------------------------------------------------------------------------
  // Next-state / datapath
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_rem_nxt   = r_rem;
    w_dir_nxt   = r_dir;
    w_wrap_nxt  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // load wins over a simultaneous start; that start is dropped.
        if (bus.load) begin
          w_q_nxt = bus.load_q;
        end else if (bus.start) begin
          w_rem_nxt   = bus.steps;
          w_dir_nxt   = bus.dir;
          w_state_nxt = (bus.steps != c_rem_zero) ? ST_RUN : ST_DONE;
        end
      end

      ST_RUN: begin
        if (!bus.hold) begin
          w_q_nxt    = w_q_shift;
          w_rem_nxt  = r_rem - c_rem_one;
          w_wrap_nxt = (w_q_shift == c_q_zero);
          if (r_rem == c_rem_one) begin
            w_state_nxt = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

`ifdef JC_SELF_CORRECT_EN
    // Correction overrides shift, load and hold. It is not a shift, so it
    // never raises wrap. A run caught mid-way ends through DONE.
    if (w_illegal) begin
      w_q_nxt    = c_q_zero;
      w_wrap_nxt = 1'b0;
      if (r_state == ST_RUN) begin
        w_state_nxt = ST_DONE;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_q     <= c_q_zero;
      r_rem   <= c_rem_zero;
      r_dir   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_rem   <= w_rem_nxt;
      r_dir   <= w_dir_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

`ifdef JC_SELF_CORRECT_EN
  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_illegal) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.q     = r_q;
  assign bus.ready = (r_state == ST_IDLE);
  assign bus.busy  = (r_state != ST_IDLE);
  assign bus.done  = (r_state == ST_DONE);
  assign bus.wrap  = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_johncount_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_johncount_ctrl
//  Description : Scoreboard bench for johncount_ctrl. Stimulus pushes the
//                hand-computed outputs expected after each clock edge into a
//                queue; a monitor pops and compares on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_johncount_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic clk;
  logic reset;

  johncount_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  johncount_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               cyc;
    int               tno;
    int               idx;
    logic [WIDTH-1:0] q;
    logic             rdy;
    logic             dn;
    logic             wr;
    logic             er;
  } exp_t;

  exp_t expq[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tno      = 0;
  int   idx      = 0;
  logic err_exp  = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor: compare every expectation whose target cycle has arrived.
  always @(negedge clk) begin
    exp_t e;
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      e = expq.pop_front();
      n_checks++;
      if (e.cyc != cyc || bus.q !== e.q || bus.ready !== e.rdy ||
          bus.busy !== ~e.rdy || bus.done !== e.dn || bus.wrap !== e.wr ||
          bus.err !== e.er) begin
        n_fail++;
        $display("FAIL t%0d_c%0d: got q=%b ready=%b busy=%b done=%b wrap=%b err=%b, expected q=%b ready=%b busy=%b done=%b wrap=%b err=%b",
                 e.tno, e.idx, bus.q, bus.ready, bus.busy, bus.done, bus.wrap,
                 bus.err, e.q, e.rdy, ~e.rdy, e.dn, e.wr, e.er);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect the given outputs after the next edge, then take that edge.
  task automatic step(input logic [WIDTH-1:0] q, input logic rdy,
                      input logic dn, input logic wr);
    exp_t e;
    e.cyc = cyc + 1;
    e.tno = tno;
    e.idx = idx;
    e.q   = q;
    e.rdy = rdy;
    e.dn  = dn;
    e.wr  = wr;
    e.er  = err_exp;
    expq.push_back(e);
    idx++;
    tick();
  endtask

  task automatic test(input int n);
    tno = n;
    idx = 0;
  endtask

  task automatic quiet();
    bus.start  = 1'b0;
    bus.steps  = '0;
    bus.dir    = 1'b0;
    bus.hold   = 1'b0;
    bus.load   = 1'b0;
    bus.load_q = '0;
  endtask

  task automatic cmd_start(input logic [CNT_W-1:0] n, input logic d);
    bus.start = 1'b1;
    bus.steps = n;
    bus.dir   = d;
  endtask

  task automatic cmd_load(input logic [WIDTH-1:0] v);
    bus.load   = 1'b1;
    bus.load_q = v;
  endtask

  initial begin
    reset = 1'b1;
    quiet();
    tick();
    tick();

    // Reset state
    test(0);
    step(4'b0000, 1, 0, 0);
    reset = 1'b0;

    // Forward 5
    test(1);
    cmd_start(8'd5, 1'b0);
    step(4'b0000, 0, 0, 0);
    quiet();
    step(4'b0001, 0, 0, 0);
    step(4'b0011, 0, 0, 0);
    step(4'b0111, 0, 0, 0);
    step(4'b1111, 0, 0, 0);
    step(4'b1110, 0, 1, 0);
    step(4'b1110, 1, 0, 0);

    // Full ring forward: wrap and done coincide
    test(2);
    cmd_load(4'b0000);
    step(4'b0000, 1, 0, 0);
    quiet();
    cmd_start(8'd8, 1'b0);
    step(4'b0000, 0, 0, 0);
    quiet();
    step(4'b0001, 0, 0, 0);
    step(4'b0011, 0, 0, 0);
    step(4'b0111, 0, 0, 0);
    step(4'b1111, 0, 0, 0);
    step(4'b1110, 0, 0, 0);
    step(4'b1100, 0, 0, 0);
    step(4'b1000, 0, 0, 0);
    step(4'b0000, 0, 1, 1);
    step(4'b0000, 1, 0, 0);

    // Reverse 3
    test(3);
    cmd_start(8'd3, 1'b1);
    step(4'b0000, 0, 0, 0);
    quiet();
    step(4'b1000, 0, 0, 0);
    step(4'b1100, 0, 0, 0);
    step(4'b1110, 0, 1, 0);
    step(4'b1110, 1, 0, 0);

    // Hold for 3 cycles after the 2nd shift of a 6-step run
    test(4);
    cmd_load(4'b0000);
    step(4'b0000, 1, 0, 0);
    quiet();
    cmd_start(8'd6, 1'b0);
    step(4'b0000, 0, 0, 0);
    quiet();
    step(4'b0001, 0, 0, 0);
    step(4'b0011, 0, 0, 0);
    bus.hold = 1'b1;
    step(4'b0011, 0, 0, 0);
    step(4'b0011, 0, 0, 0);
    step(4'b0011, 0, 0, 0);
    bus.hold = 1'b0;
    step(4'b0111, 0, 0, 0);
    step(4'b1111, 0, 0, 0);
    step(4'b1110, 0, 0, 0);
    step(4'b1100, 0, 1, 0);
    step(4'b1100, 1, 0, 0);

    // steps=0: immediate done, q unchanged
    test(5);
    cmd_start(8'd0, 1'b0);
    step(4'b1100, 0, 1, 0);
    quiet();
    step(4'b1100, 1, 0, 0);

    // start re-pulsed mid-run is ignored; the shift into 0000 raises wrap
    test(6);
    cmd_start(8'd2, 1'b0);
    step(4'b1100, 0, 0, 0);
    cmd_start(8'd9, 1'b1);
    step(4'b1000, 0, 0, 0);
    step(4'b0000, 0, 1, 1);
    quiet();
    step(4'b0000, 1, 0, 0);

    // load with start: load wins, no run
    test(7);
    cmd_load(4'b0111);
    cmd_start(8'd4, 1'b0);
    step(4'b0111, 1, 0, 0);
    quiet();
    step(4'b0111, 1, 0, 0);
    step(4'b0111, 1, 0, 0);

    // Reset at the 3rd shift of a 7-step run: no done pulse
    test(8);
    cmd_load(4'b0000);
    step(4'b0000, 1, 0, 0);
    quiet();
    cmd_start(8'd7, 1'b0);
    step(4'b0000, 0, 0, 0);
    quiet();
    step(4'b0001, 0, 0, 0);
    step(4'b0011, 0, 0, 0);
    reset = 1'b1;
    step(4'b0000, 1, 0, 0);
    reset = 1'b0;
    step(4'b0000, 1, 0, 0);
    step(4'b0000, 1, 0, 0);

    // Illegal code 0101
    test(9);
    cmd_load(4'b0101);
    step(4'b0101, 1, 0, 0);
    quiet();
`ifdef JC_SELF_CORRECT_EN
    err_exp = 1'b1;
    step(4'b0000, 1, 0, 0);
    step(4'b0000, 1, 0, 0);
    cmd_start(8'd2, 1'b0);
    step(4'b0000, 0, 0, 0);
    quiet();
    step(4'b0001, 0, 0, 0);
    step(4'b0011, 0, 1, 0);
    step(4'b0011, 1, 0, 0);
    reset = 1'b1;
    err_exp = 1'b0;
    step(4'b0000, 1, 0, 0);
    reset = 1'b0;
`else
    cmd_start(8'd1, 1'b0);
    step(4'b0101, 0, 0, 0);
    quiet();
    step(4'b1011, 0, 1, 0);
    step(4'b1011, 1, 0, 0);
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && expq.size() > 0; i++) tick();
    if (expq.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", expq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
